muxn_pipe: RTL and testbench

- Parametrised N-way word selector with a registered, valid/ready-handshaked output stage.
- Generalises the 3:1 combinational operand/writeback mux in width and input count.
- Out-of-range selects produce a defined value and raise a sticky error flag; they never produce X.
- Used at pipeline-register boundaries of the RISC-V datapath (forwarding/writeback select), where back-pressure from the next stage must be absorbed without losing throughput.

---
 rtl/muxn_pkg.sv | 16 +
 rtl/muxn_sel.sv | 40 ++++
 rtl/muxn_pipe.sv | 117 +++++++++++
 tb/tb_muxn_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/muxn_pkg.sv
// Shared types and helpers for the N-way registered word selector.
package muxn_pkg;

  // Two-entry output buffer occupancy: main register only, or main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } muxn_state_e;

  // Select width for n inputs; a single input still gets a 1-bit select.
  function automatic int muxn_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/muxn_sel.sv
// Combinational N-way word selector with a default word and out-of-range flag.
module muxn_sel
  import muxn_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter int               N_IN  = 3,
  parameter int               SEL_W = muxn_sel_w(N_IN),
  parameter logic [WIDTH-1:0] DFLT  = '0
) (
  input  logic [N_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      data,
  output logic                  oor
);

  localparam logic [SEL_W:0] N_IN_L = (SEL_W + 1)'(N_IN);

  logic [WIDTH-1:0] words [N_IN];

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_unpack
      assign words[gi] = in_bus[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // One extra bit on the compare so a power-of-two N_IN never flags.
  assign oor = ({1'b0, sel} >= N_IN_L);

  // Explicit match per input keeps an out-of-range select from indexing past the array.
  always_comb begin
    data = DFLT;
    for (int i = 0; i < N_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        data = words[i];
      end
    end
  end

endmodule

// File: rtl/muxn_pipe.sv
// N-way word selector followed by a valid/ready output stage with a skid
// register, so back-pressure is absorbed at full throughput.
module muxn_pipe
  import muxn_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter int               N_IN  = 3,
  parameter int               SEL_W = muxn_sel_w(N_IN),
  parameter logic [WIDTH-1:0] DFLT  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err,
  input  logic                  err_clr
);

  muxn_state_e      state_reg, state_next;
  logic [WIDTH-1:0] main_reg, main_next;
  logic [WIDTH-1:0] skid_reg, skid_next;
  logic             in_ready_reg, in_ready_next;
  logic             sel_err_reg, sel_err_next;

  logic [WIDTH-1:0] sel_data;
  logic             sel_oor;
  logic             accept;
  logic             xfer;

  muxn_sel #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN),
    .SEL_W (SEL_W),
    .DFLT  (DFLT)
  ) u_sel (
    .in_bus (in_bus),
    .sel    (sel),
    .data   (sel_data),
    .oor    (sel_oor)
  );

  assign out_valid = (state_reg != ST_EMPTY);
  assign out_data  = main_reg;
  assign in_ready  = in_ready_reg;
  assign sel_err   = sel_err_reg;

  assign accept = in_valid & in_ready_reg;
  assign xfer   = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) begin
          state_next = ST_ONE;
          main_next  = sel_data;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          main_next = sel_data;
        end else if (accept) begin
          state_next = ST_TWO;
          skid_next  = sel_data;
        end else if (xfer) begin
          state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the drain of the main register can happen.
        if (xfer) begin
          state_next = ST_ONE;
          main_next  = skid_reg;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
  end

  assign in_ready_next = (state_next != ST_TWO);

  // A bad beat landing on the same edge as a clear keeps the flag set.
  always_comb begin
    sel_err_next = sel_err_reg;
    if (accept && sel_oor) begin
      sel_err_next = 1'b1;
    end else if (err_clr) begin
      sel_err_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
      sel_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      in_ready_reg <= in_ready_next;
      sel_err_reg  <= sel_err_next;
    end
  end

endmodule

// File: tb/tb_muxn_pipe.sv
// Directed vector table on a 32-bit 3-input instance, async reset check,
// and randomised scoreboard runs on 8-bit 1-input and 8-input instances.
module tb_muxn_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  // 32-bit, 3-input instance
  logic [95:0] m_bus;
  logic [1:0]  m_sel;
  logic        m_iv, m_ir, m_ov, m_or, m_err, m_clr;
  logic [31:0] m_od;

  muxn_pipe #(.WIDTH(32), .N_IN(3), .DFLT(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst), .in_bus(m_bus), .sel(m_sel), .in_valid(m_iv),
    .in_ready(m_ir), .out_data(m_od), .out_valid(m_ov), .out_ready(m_or),
    .sel_err(m_err), .err_clr(m_clr)
  );

  // 8-bit, 1-input instance
  logic [7:0] a_bus, a_od;
  logic       a_sel, a_iv, a_ir, a_ov, a_or, a_err, a_clr;

  muxn_pipe #(.WIDTH(8), .N_IN(1), .DFLT(8'hA5)) dut1 (
    .clk(clk), .rst(rst), .in_bus(a_bus), .sel(a_sel), .in_valid(a_iv),
    .in_ready(a_ir), .out_data(a_od), .out_valid(a_ov), .out_ready(a_or),
    .sel_err(a_err), .err_clr(a_clr)
  );

  // 8-bit, 8-input instance
  logic [63:0] b_bus;
  logic [2:0]  b_sel;
  logic [7:0]  b_od;
  logic        b_iv, b_ir, b_ov, b_or, b_err, b_clr;

  muxn_pipe #(.WIDTH(8), .N_IN(8), .DFLT(8'h5A)) dut8 (
    .clk(clk), .rst(rst), .in_bus(b_bus), .sel(b_sel), .in_valid(b_iv),
    .in_ready(b_ir), .out_data(b_od), .out_valid(b_ov), .out_ready(b_or),
    .sel_err(b_err), .err_clr(b_clr)
  );

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic        ordy;
    logic        clr;
    logic        ev;
    logic        chk_d;
    logic [31:0] ed;
    logic        er;
    logic        ee;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input logic ev, input logic chk_d,
                             input logic [31:0] ed, input logic er, input logic ee);
    check({tag, ".out_valid"}, 32'(m_ov), 32'(ev));
    if (chk_d) check({tag, ".out_data"}, m_od, ed);
    check({tag, ".in_ready"}, 32'(m_ir), 32'(er));
    check({tag, ".sel_err"}, 32'(m_err), 32'(ee));
  endtask

  task automatic apply(input int idx);
    @(negedge clk);
    m_iv  = vecs[idx].iv;
    m_sel = vecs[idx].sel;
    m_or  = vecs[idx].ordy;
    m_clr = vecs[idx].clr;
    @(posedge clk);
    #1;
    check_state($sformatf("vec%0d", idx), vecs[idx].ev, vecs[idx].chk_d,
                vecs[idx].ed, vecs[idx].er, vecs[idx].ee);
    $display("vec %0d: iv=%b sel=%0d ordy=%b clr=%b -> ov=%b od=%h ir=%b err=%b",
             idx, m_iv, m_sel, m_or, m_clr, m_ov, m_od, m_ir, m_err);
  endtask

  initial begin
    //          iv    sel    ordy  clr   ev    chk   data           ir    err
    vecs[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000011, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000022, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000033, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000011, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000011, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000011, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000022, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1};

    rst   = 1'b1;
    m_bus = {32'h00000033, 32'h00000022, 32'h00000011};
    m_sel = '0; m_iv = 1'b0; m_or = 1'b0; m_clr = 1'b0;
    a_bus = '0; a_sel = 1'b0; a_iv = 1'b0; a_or = 1'b0; a_clr = 1'b0;
    b_bus = '0; b_sel = '0;   b_iv = 1'b0; b_or = 1'b0; b_clr = 1'b0;

    repeat (2) @(negedge clk);
    check_state("reset", 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    $display("reset: ov=%b od=%h ir=%b err=%b", m_ov, m_od, m_ir, m_err);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) apply(i);

    // Asynchronous reset while two beats are held (state TWO, sel_err set)
    @(negedge clk);
    m_iv = 1'b0; m_or = 1'b0; m_clr = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_state("async_rst", 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    $display("async reset asserted: ov=%b od=%h ir=%b err=%b", m_ov, m_od, m_ir, m_err);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_state("post_rst", 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    $display("after reset release: ov=%b od=%h ir=%b err=%b", m_ov, m_od, m_ir, m_err);

    // First beat after reset goes straight through with one cycle of latency
    @(negedge clk);
    m_iv = 1'b1; m_sel = 2'd2; m_or = 1'b1;
    @(posedge clk);
    #1;
    check_state("post_rst_beat", 1'b1, 1'b1, 32'h33, 1'b1, 1'b0);
    $display("beat after reset: ov=%b od=%h ir=%b err=%b", m_ov, m_od, m_ir, m_err);
    @(negedge clk);
    m_iv = 1'b0;

    // Randomised scoreboard runs on the 1-input and 8-input instances
    fork
      begin : sweep_n1
        int         beats;
        int         cyc;
        logic       bad;
        logic [7:0] q [$];
        logic [7:0] exp_w;
        beats = 0; cyc = 0; bad = 1'b0;
        while (beats < 10000 && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          a_iv  = ($urandom_range(0, 3) != 0);
          a_sel = ($urandom_range(0, 3) == 0);
          a_bus = 8'($urandom);
          a_or  = ($urandom_range(0, 3) != 0);
          #4;
          if (a_ov && a_or) begin
            if (q.size() == 0) begin
              checks++; errors++;
              $display("FAIL n1_extra_beat: got %h expected no beat", a_od);
            end else begin
              exp_w = q.pop_front();
              check("n1_data", 32'(a_od), 32'(exp_w));
            end
            beats++;
            if (beats % 2500 == 0) $display("n1 sweep: %0d beats delivered", beats);
          end
          if (a_iv && a_ir) begin
            q.push_back(a_sel ? 8'hA5 : a_bus);
            if (a_sel) bad = 1'b1;
          end
        end
        check("n1_beats", beats, 10000);
        check("n1_sel_err", 32'(a_err), 32'(bad));
        a_iv = 1'b0;
      end
      begin : sweep_n8
        int         beats;
        int         cyc;
        logic [7:0] q [$];
        logic [7:0] exp_w;
        beats = 0; cyc = 0;
        while (beats < 10000 && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          b_iv  = ($urandom_range(0, 3) != 0);
          b_sel = 3'($urandom);
          b_bus = {$urandom, $urandom};
          b_or  = ($urandom_range(0, 3) != 0);
          #4;
          if (b_ov && b_or) begin
            if (q.size() == 0) begin
              checks++; errors++;
              $display("FAIL n8_extra_beat: got %h expected no beat", b_od);
            end else begin
              exp_w = q.pop_front();
              check("n8_data", 32'(b_od), 32'(exp_w));
            end
            beats++;
            if (beats % 2500 == 0) $display("n8 sweep: %0d beats delivered", beats);
          end
          if (b_iv && b_ir) q.push_back(b_bus[b_sel*8 +: 8]);
        end
        check("n8_beats", beats, 10000);
        check("n8_sel_err", 32'(b_err), 32'h0);
        b_iv = 1'b0;
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
